// File: rtl/error_detect_stage_if.sv
// Bundles the sampling handshake, the compared data words and the
// dual-rail error result of one error-detect stage.
interface error_detect_stage_if #(
  parameter int WIDTH = 8
);
  logic             sample;
  logic [WIDTH-1:0] d_main;
  logic [WIDTH-1:0] d_shadow;
  logic             err_mask;
  logic             cnt_clr;
  logic             Err1;
  logic             Err0;
  logic [7:0]       err_count;
  logic             burst;

  // Stage controller / environment side
  modport master (
    output sample, d_main, d_shadow, err_mask, cnt_clr,
    input  Err1, Err0, err_count, burst
  );

  // Detector side
  modport slave (
    input  sample, d_main, d_shadow, err_mask, cnt_clr,
    output Err1, Err0, err_count, burst
  );
endinterface

// File: rtl/error_detect_stage.sv
// Timing-error detector: compares main and shadow latch words when the
// (asynchronous, synchronized) sample request rises and reports the result
// on a dual-rail Err1/Err0 pair that returns to spacer when sample falls.
// Also keeps a saturating total-error count and a consecutive-error burst flag.
module error_detect_stage #(
  parameter int WIDTH      = 8,
  parameter int ERR_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst,
  error_detect_stage_if.slave bus
);

  typedef enum logic {SPACER = 1'b0, VALID = 1'b1} state_t;

  localparam logic [3:0] THRESH = 4'(ERR_THRESH);

  logic             r_sync1, r_sync2;
  state_t           r_state, w_next;
  logic             w_eval, w_release;
  logic [WIDTH-1:0] w_main, w_shadow;
  logic             w_mismatch;
  logic             r_err1, r_err0;
  logic [7:0]       r_err_count;
  logic [3:0]       r_cons;
  logic             r_burst;

  assign w_main     = bus.d_main;
  assign w_shadow   = bus.d_shadow;
  assign w_mismatch = (w_main != w_shadow) && !bus.err_mask;

  // Two-flop synchronizer for the asynchronous sample request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.sample;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SPACER;
    else     r_state <= w_next;
  end

  // FSM next state; flags the evaluate and release edges
  always_comb begin
    w_next    = r_state;
    w_eval    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      SPACER: if (r_sync2) begin
        w_next = VALID;
        w_eval = 1'b1;
      end
      VALID: if (!r_sync2) begin
        w_next    = SPACER;
        w_release = 1'b1;
      end
      default: w_next = SPACER;
    endcase
  end

  // Dual-rail result: both rails written together so they stay one-hot/spacer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err1 <= 1'b0;
      r_err0 <= 1'b0;
    end else if (w_eval) begin
      r_err1 <= w_mismatch;
      r_err0 <= !w_mismatch;
    end else if (w_release) begin
      r_err1 <= 1'b0;
      r_err0 <= 1'b0;
    end
  end

  // Saturating total error counter; a clear coincident with an error leaves 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_eval && w_mismatch) begin
      if (bus.cnt_clr)                r_err_count <= 8'd1;
      else if (r_err_count != 8'hFF)  r_err_count <= r_err_count + 8'd1;
    end else if (bus.cnt_clr) begin
      r_err_count <= 8'd0;
    end
  end

  // Consecutive error counter, cleared by any no-error evaluation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cons <= 4'd0;
    end else if (w_eval) begin
      if (!w_mismatch)            r_cons <= 4'd0;
      else if (r_cons != 4'hF)    r_cons <= r_cons + 4'd1;
    end
  end

  // Burst flag registered one edge behind the consecutive counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_burst <= 1'b0;
    else     r_burst <= (r_cons >= THRESH);
  end

  assign bus.Err1      = r_err1;
  assign bus.Err0      = r_err0;
  assign bus.err_count = r_err_count;
  assign bus.burst     = r_burst;

endmodule

// File: tb/tb_error_detect_stage.sv
// Directed bench for error_detect_stage plus a randomized rail check
// against a small cycle model of the synchronizer and FSM.
module tb_error_detect_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  error_detect_stage_if #(.WIDTH(8)) bus ();

  error_detect_stage #(.WIDTH(8), .ERR_THRESH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sample cycle; cnt_clr (if requested) is applied only on the evaluate edge
  task automatic do_eval(input logic [7:0] m, input logic [7:0] s, input logic mask,
                         input logic clr, output logic e1, output logic e0);
    bus.d_main   = m;
    bus.d_shadow = s;
    bus.err_mask = mask;
    bus.sample   = 1'b1;
    tick();
    tick();
    bus.cnt_clr = clr;
    tick();
    bus.cnt_clr = 1'b0;
    e1 = bus.Err1;
    e0 = bus.Err0;
    bus.sample = 1'b0;
    tick();
    tick();
    tick();
  endtask

  logic e1, e0;
  // cycle model for the random phase
  logic m_s1, m_s2, m_state, m_e1, m_e0;
  logic smp;
  logic [7:0] rm, rs;
  logic rk;

  initial begin
    bus.sample = 1'b0; bus.d_main = 8'h00; bus.d_shadow = 8'h00;
    bus.err_mask = 1'b0; bus.cnt_clr = 1'b0;

    // reset state
    #2;
    chk("rst_err1", 32'(bus.Err1), 0);
    chk("rst_err0", 32'(bus.Err0), 0);
    chk("rst_count", 32'(bus.err_count), 0);
    chk("rst_burst", 32'(bus.burst), 0);
    tick(); tick();
    rst = 1'b0;

    // no-error evaluation with latency checks
    bus.d_main = 8'hA5; bus.d_shadow = 8'hA5; bus.sample = 1'b1;
    tick(); chk("lat_n", 32'(bus.Err0), 0);
    tick(); chk("lat_n1", 32'(bus.Err0), 0);
    tick(); chk("lat_n2_err0", 32'(bus.Err0), 1);
    chk("lat_n2_err1", 32'(bus.Err1), 0);
    bus.sample = 1'b0;
    tick(); chk("rel_m", 32'(bus.Err0), 1);
    tick(); chk("rel_m1", 32'(bus.Err0), 1);
    tick(); chk("rel_m2", 32'({bus.Err1, bus.Err0}), 0);
    chk("noerr_count", 32'(bus.err_count), 0);

    // mismatch, then masked mismatch
    do_eval(8'hA5, 8'hA4, 1'b0, 1'b0, e1, e0);
    chk("err_rails", 32'({e1, e0}), 32'b10);
    chk("err_count1", 32'(bus.err_count), 1);
    do_eval(8'hA5, 8'hA4, 1'b1, 1'b0, e1, e0);
    chk("mask_rails", 32'({e1, e0}), 32'b01);
    chk("mask_count", 32'(bus.err_count), 1);

    // rails hold while data and mask change in VALID
    bus.d_main = 8'h3C; bus.d_shadow = 8'h3D; bus.err_mask = 1'b0; bus.sample = 1'b1;
    tick(); tick(); tick();
    chk("hold_pre", 32'({bus.Err1, bus.Err0}), 32'b10);
    bus.d_shadow = 8'h3C; bus.err_mask = 1'b1;
    tick(); tick();
    chk("hold_post", 32'({bus.Err1, bus.Err0}), 32'b10);
    bus.sample = 1'b0; bus.err_mask = 1'b0;
    tick(); tick(); tick();
    chk("hold_count", 32'(bus.err_count), 2);

    // burst: clear run with a match, then three mismatches, then a match
    do_eval(8'h11, 8'h11, 1'b0, 1'b0, e1, e0);
    do_eval(8'h11, 8'h12, 1'b0, 1'b0, e1, e0);
    do_eval(8'h11, 8'h13, 1'b0, 1'b0, e1, e0);
    chk("burst_after2", 32'(bus.burst), 0);
    do_eval(8'h11, 8'h14, 1'b0, 1'b0, e1, e0);
    chk("burst_after3", 32'(bus.burst), 1);
    chk("burst_count", 32'(bus.err_count), 5);
    do_eval(8'h22, 8'h22, 1'b0, 1'b0, e1, e0);
    chk("burst_match", 32'(bus.burst), 0);

    // saturation and clear
    for (int i = 0; i < 260; i++) do_eval(8'hF0, 8'h0F, 1'b0, 1'b0, e1, e0);
    chk("sat_count", 32'(bus.err_count), 255);
    chk("sat_burst", 32'(bus.burst), 1);
    do_eval(8'hF0, 8'h0F, 1'b0, 1'b1, e1, e0);
    chk("clr_with_err", 32'(bus.err_count), 1);
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    chk("clr_alone", 32'(bus.err_count), 0);
    chk("clr_keeps_burst", 32'(bus.burst), 1);

    // pulse shorter than a period, placed between edges
    bus.d_main = 8'h01; bus.d_shadow = 8'h02;
    bus.sample = 1'b1; #3; bus.sample = 1'b0;
    tick(); tick(); tick(); tick();
    chk("glitch_rails", 32'({bus.Err1, bus.Err0}), 0);
    chk("glitch_count", 32'(bus.err_count), 0);

    // reset in VALID with Err1 high, then re-evaluation of a held sample
    bus.sample = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_err1", 32'(bus.Err1), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rails", 32'({bus.Err1, bus.Err0}), 0);
    chk("midrst_count", 32'(bus.err_count), 0);
    chk("midrst_burst", 32'(bus.burst), 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(); tick();
    chk("resync_early", 32'({bus.Err1, bus.Err0}), 0);
    tick();
    chk("resync_rails", 32'({bus.Err1, bus.Err0}), 32'b10);
    chk("resync_count", 32'(bus.err_count), 1);
    bus.sample = 1'b0;
    tick(); tick(); tick();

    // randomized invariant phase against a cycle model
    rst = 1'b1; tick(); rst = 1'b0;
    m_s1 = 0; m_s2 = 0; m_state = 0; m_e1 = 0; m_e0 = 0;
    for (int c = 0; c < 10000; c++) begin
      smp = 1'($urandom_range(0, 1));
      rm  = 8'($urandom_range(0, 3));
      rs  = 8'($urandom_range(0, 3));
      rk  = ($urandom_range(0, 3) == 0);
      bus.sample = smp; bus.d_main = rm; bus.d_shadow = rs; bus.err_mask = rk;
      tick();
      if (!m_state && m_s2) begin
        m_state = 1'b1;
        m_e1 = (rm != rs) && !rk;
        m_e0 = !m_e1;
      end else if (m_state && !m_s2) begin
        m_state = 1'b0;
        m_e1 = 1'b0; m_e0 = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = smp;
      chk("rand_onehot", 32'(bus.Err1 & bus.Err0), 0);
      chk("rand_rails", 32'({bus.Err1, bus.Err0}), 32'({m_e1, m_e0}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
